// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one single-ported RAM between the icache and the dcache.
// One word transaction at a time. The dcache wins when both caches request in the same cycle.
// The RAM-side signals and the wait/load handshakes are combinational from the granted requester.
// Optional build macro ARB_STARVE_GUARD_EN enables the starvation guard and its STARVE_MAX
// parameter. After STARVE_MAX consecutive dcache grants made while the icache waited, the
// icache is granted next.
module cache_mem_arbiter
`ifdef ARB_STARVE_GUARD_EN
  #(parameter int unsigned STARVE_MAX = 4)
`endif
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state, next_state;
  logic   d_req;
  logic   ram_done;
  logic   force_i;
  logic   unused_addr_bits;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS);

  // The RAM is word addressed, so the byte-offset bits are never used.
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign force_i = (starve_cnt == STARVE_MAX[2:0]);

  // Count the dcache grants made while the icache is waiting. Clear on an icache grant or when the icache is idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if ((next_state == SERVE_I) || !iREN)
        starve_cnt <= '0;
      else if ((next_state == SERVE_D) && (starve_cnt != 3'd7))
        starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // State register; the state also encodes which cache holds the grant
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: grant in IDLE, then release on completion or when the requester drops its request
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (iREN && (force_i || !d_req)) next_state = SERVE_I;
        else if (d_req)                  next_state = SERVE_D;
        else                             next_state = IDLE;
      end
      SERVE_I: if (!iREN || ram_done)  next_state = IDLE;
      SERVE_D: if (!d_req || ram_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: drive the RAM from the live inputs of the granted cache and pulse its wait low on ACCESS
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      SERVE_I: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = {iaddr[31:2], 2'b00};
          if (ram_done) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end
      SERVE_D: begin
        if (d_req) begin
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          ramaddr  = {daddr[31:2], 2'b00};
          ramstore = dWEN ? dstore : 32'd0;
          if (ram_done) begin
            dwait = 1'b0;
            dload = dWEN ? 32'd0 : ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
